// File: rtl/power_seq_ctrl.sv
// power_seq_ctrl: N-step power sequencer for sensor rails and control pins.
// Raises each step in order after a programmable delay, optionally waits for
// its power-good, lowers steps in reverse order on power-down, and latches
// a fault on power-good timeout or brown-out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_OFF    | all steps inactive, waiting for pwr_req
// S_UP_DLY | counting the pre-assert delay of step k
// S_UP_PG  | step k asserted, waiting for its synchronised power-good
// S_ON     | every step active, ready high
// S_DOWN   | counting the revert delay of step k, walking down to step 0
// S_FAULT  | all steps forced off, held until pwr_req drops
module power_seq_ctrl #(
    parameter int                       N_STEP     = 6,
    parameter int                       CNT_W      = 21,
    parameter int                       IDX_W      = 3,
    parameter logic [N_STEP*CNT_W-1:0]  STEP_DLY   = {6{21'd25000}},
    parameter logic [CNT_W-1:0]         DOWN_DLY   = 21'd25000,
    parameter logic [N_STEP-1:0]        OFF_VAL    = 6'b001000,
    parameter logic [N_STEP-1:0]        PG_MASK    = 6'b000111,
    parameter logic [CNT_W-1:0]         PG_TIMEOUT = 21'd50000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pwr_req,
    input  logic [N_STEP-1:0] pg,
    output logic [N_STEP-1:0] seq_out,
    output logic              ready,
    output logic              busy,
    output logic              fault,
    output logic [IDX_W-1:0]  fault_step
);

    typedef enum logic [2:0] {
        S_OFF, S_UP_DLY, S_UP_PG, S_ON, S_DOWN, S_FAULT
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  k, k_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_STEP-1:0] pg_m, pg_s;

    logic [N_STEP-1:0] active, exempt, bad;
    logic              mon_fault, last_step, dly_hit;
    logic [IDX_W-1:0]  mon_idx, flt_idx;
    logic              assert_k, revert_k;

    logic [N_STEP-1:0] seq_nxt;
    logic              ready_nxt, busy_nxt, fault_nxt;
    logic [IDX_W-1:0]  fault_step_nxt;

    // Two-flop synchroniser for the asynchronous power-good inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pg_m <= '0;
            pg_s <= '0;
        end else begin
            pg_m <= pg;
            pg_s <= pg_m;
        end
    end

    // A step is active when its output differs from its inactive level; the
    // step still waiting for its own first power-good is not yet monitored.
    assign active    = seq_out ^ OFF_VAL;
    assign exempt    = (state == S_UP_PG) ? (N_STEP'(1) << k) : '0;
    assign bad       = active & PG_MASK & ~exempt & ~pg_s;
    assign last_step = (k == IDX_W'(N_STEP - 1));
    assign dly_hit   = (cnt == STEP_DLY[int'(k)*CNT_W +: CNT_W]);

    // Lowest-numbered failing monitored step wins.
    always_comb begin
        mon_fault = |bad;
        mon_idx   = '0;
        for (int i = N_STEP - 1; i >= 0; i--) begin
            if (bad[i]) mon_idx = IDX_W'(i);
        end
    end

    // State register, step index, counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_OFF;
            k          <= '0;
            cnt        <= '0;
            seq_out    <= OFF_VAL;
            ready      <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_step <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            cnt        <= cnt_nxt;
            seq_out    <= seq_nxt;
            ready      <= ready_nxt;
            busy       <= busy_nxt;
            fault      <= fault_nxt;
            fault_step <= fault_step_nxt;
        end
    end

    // Next-state logic: faults first, then timeout, then abort, then progress.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        assert_k  = 1'b0;
        revert_k  = 1'b0;
        flt_idx   = mon_idx;
        unique case (state)
            S_OFF: begin
                if (pwr_req) begin
                    state_nxt = S_UP_DLY;
                    k_nxt     = '0;
                end
            end
            S_UP_DLY: begin
                if (mon_fault) begin
                    state_nxt = S_FAULT;
                end else if (!pwr_req) begin
                    if (k == '0) begin
                        state_nxt = S_OFF;
                    end else begin
                        state_nxt = S_DOWN;
                        k_nxt     = k - IDX_W'(1);
                    end
                end else if (dly_hit) begin
                    assert_k = 1'b1;
                    if (PG_MASK[k]) begin
                        state_nxt = S_UP_PG;
                    end else if (!last_step) begin
                        k_nxt = k + IDX_W'(1);
                    end else begin
                        state_nxt = S_ON;
                    end
                end
            end
            S_UP_PG: begin
                if (mon_fault) begin
                    state_nxt = S_FAULT;
                end else if (!pg_s[k] && cnt == PG_TIMEOUT) begin
                    state_nxt = S_FAULT;
                    flt_idx   = k;
                end else if (!pwr_req) begin
                    state_nxt = S_DOWN;
                end else if (pg_s[k]) begin
                    if (last_step) begin
                        state_nxt = S_ON;
                    end else begin
                        state_nxt = S_UP_DLY;
                        k_nxt     = k + IDX_W'(1);
                    end
                end
            end
            S_ON: begin
                if (mon_fault) begin
                    state_nxt = S_FAULT;
                end else if (!pwr_req) begin
                    state_nxt = S_DOWN;
                    k_nxt     = IDX_W'(N_STEP - 1);
                end
            end
            S_DOWN: begin
                if (mon_fault) begin
                    state_nxt = S_FAULT;
                end else if (cnt == DOWN_DLY) begin
                    revert_k = 1'b1;
                    if (k == '0) begin
                        state_nxt = S_OFF;
                    end else begin
                        k_nxt = k - IDX_W'(1);
                    end
                end
            end
            S_FAULT: begin
                if (!pwr_req) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase

        if (state_nxt != state || k_nxt != k) begin
            cnt_nxt = '0;
        end else if (state == S_UP_DLY || state == S_UP_PG || state == S_DOWN) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end
    end

    // Output logic: values the outputs take on the coming edge.
    always_comb begin
        seq_nxt = seq_out;
        if (assert_k) seq_nxt[k] = ~OFF_VAL[k];
        if (revert_k) seq_nxt[k] = OFF_VAL[k];
        if (state_nxt == S_FAULT) seq_nxt = OFF_VAL;
        ready_nxt = (state_nxt == S_ON);
        busy_nxt  = (state_nxt == S_UP_DLY) || (state_nxt == S_UP_PG) ||
                    (state_nxt == S_DOWN);
        fault_nxt = (state_nxt == S_FAULT);
        fault_step_nxt = (state != S_FAULT && state_nxt == S_FAULT) ? flt_idx : fault_step;
    end

endmodule
